// File: rtl/bullet_pkg.sv
// bullet_pkg: shared direction type, screen limits
// and key codes for the player projectile pool.
package bullet_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    UP    = 2'b11
  } dir_t;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int SCR_X_MIN = 1;
  localparam int SCR_X_MAX = 639;
  localparam int SCR_Y_MIN = 1;
  localparam int SCR_Y_MAX = 479;

  localparam logic [7:0] KEY_SPACE = 8'd44;

endpackage

// File: rtl/bullet_pool_if.sv
// bullet_pool_if: player/keyboard inputs and packed
// bullet outputs of the projectile pool.
interface bullet_pool_if #(
  parameter int NUM_BULLETS = 4
);
  import bullet_pkg::*;

  logic [1:0]               direction;
  logic [7:0]               keycode;
  coord_t                   BallX;
  coord_t                   BallY;
  logic                     upgraded;
  logic [NUM_BULLETS-1:0]   kill;
  logic [10*NUM_BULLETS-1:0] BulletX;
  logic [10*NUM_BULLETS-1:0] BulletY;
  coord_t                   BulletS;
  logic [NUM_BULLETS-1:0]   bullet_on;
  logic [$clog2(NUM_BULLETS+1)-1:0] active_count;
  logic                     fire_event;

  modport master (
    output direction, keycode, BallX, BallY,
    output upgraded, kill,
    input  BulletX, BulletY, BulletS,
    input  bullet_on, active_count, fire_event
  );

  modport slave (
    input  direction, keycode, BallX, BallY,
    input  upgraded, kill,
    output BulletX, BulletY, BulletS,
    output bullet_on, active_count, fire_event
  );

endinterface

// File: rtl/bullet_slot.sv
// bullet_slot: one projectile; latches direction and
// position on alloc, moves each frame, dies at edge/kill.
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int STEP          = 12,
  parameter int UPGRADE_BONUS = 6,
  parameter int BULLET_SIZE   = 2,
  parameter int X_MIN         = SCR_X_MIN,
  parameter int X_MAX         = SCR_X_MAX,
  parameter int Y_MIN         = SCR_Y_MIN,
  parameter int Y_MAX         = SCR_Y_MAX
) (
  input  logic   frame_clk,
  input  logic   Reset,
  input  logic   alloc,
  input  dir_t   direction,
  input  coord_t ball_x,
  input  coord_t ball_y,
  input  logic   upgraded,
  input  logic   kill,
  output logic   active,
  output coord_t pos_x,
  output coord_t pos_y
);

  localparam coord_t BS   = coord_t'(BULLET_SIZE);
  localparam coord_t HI_X = coord_t'(X_MAX);
  localparam coord_t HI_Y = coord_t'(Y_MAX);
  localparam coord_t LO_X = coord_t'(X_MIN + BULLET_SIZE);
  localparam coord_t LO_Y = coord_t'(Y_MIN + BULLET_SIZE);

  dir_t   dir;
  coord_t d;
  coord_t sum_x;
  coord_t sum_y;
  logic   at_edge;

  // wrapped underflow lands far above MAX, so the
  // same 10-bit edge test also retires it
  always_comb begin
    d = coord_t'(STEP);
    if (upgraded)
      d = coord_t'(STEP + UPGRADE_BONUS);
    sum_x   = pos_x + BS;
    sum_y   = pos_y + BS;
    at_edge = (sum_x >= HI_X) || (pos_x <= LO_X) ||
              (sum_y >= HI_Y) || (pos_y <= LO_Y);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      active <= 1'b0;
      dir    <= LEFT;
      pos_x  <= '0;
      pos_y  <= '0;
    end else if (!active) begin
      pos_x <= ball_x;
      pos_y <= ball_y;
      if (alloc) begin
        active <= 1'b1;
        dir    <= direction;
      end
    end else if (at_edge || kill) begin
      active <= 1'b0;
    end else begin
      unique case (dir)
        LEFT:  pos_x <= pos_x - d;
        RIGHT: pos_x <= pos_x + d;
        DOWN:  pos_y <= pos_y + d;
        UP:    pos_y <= pos_y - d;
      endcase
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// bullet_pool: press tracking, fire cooldown, lowest-free
// slot allocation and output packing for NUM_BULLETS slots.
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int         NUM_BULLETS     = 4,
  parameter logic [7:0] FIRE_KEY        = KEY_SPACE,
  parameter int         STEP            = 12,
  parameter int         UPGRADE_BONUS   = 6,
  parameter int         COOLDOWN_FRAMES = 8,
  parameter int         BULLET_SIZE     = 2,
  parameter int         X_MIN           = SCR_X_MIN,
  parameter int         X_MAX           = SCR_X_MAX,
  parameter int         Y_MIN           = SCR_Y_MIN,
  parameter int         Y_MAX           = SCR_Y_MAX
) (
  input logic frame_clk,
  input logic Reset,
  bullet_pool_if.slave bus
);

  localparam int CW = (COOLDOWN_FRAMES > 0) ?
                      $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int AW = $clog2(NUM_BULLETS + 1);

  logic                   released;
  logic [CW-1:0]          cooldown;
  logic                   fire_event;
  logic                   fire_key;
  logic                   fire;
  logic [NUM_BULLETS-1:0] active;
  logic [NUM_BULLETS-1:0] free;
  logic [NUM_BULLETS-1:0] grant;
  logic [NUM_BULLETS-1:0] alloc;
  logic [AW-1:0]          cnt;
  coord_t                 px [NUM_BULLETS];
  coord_t                 py [NUM_BULLETS];

  // isolate lowest set bit of free mask
  always_comb begin
    fire_key = (bus.keycode == FIRE_KEY);
    free     = ~active;
    grant    = free & (~free + NUM_BULLETS'(1));
    fire     = fire_key && released &&
               (cooldown == '0) && (|free);
    alloc    = fire ? grant : '0;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_BULLETS; i++)
      cnt = cnt + AW'(active[i]);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      released   <= 1'b1;
      cooldown   <= '0;
      fire_event <= 1'b0;
    end else begin
      released   <= !fire_key;
      fire_event <= fire;
      if (fire)
        cooldown <= CW'(COOLDOWN_FRAMES);
      else if (cooldown != '0)
        cooldown <= cooldown - CW'(1);
    end
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .STEP          (STEP),
      .UPGRADE_BONUS (UPGRADE_BONUS),
      .BULLET_SIZE   (BULLET_SIZE),
      .X_MIN         (X_MIN),
      .X_MAX         (X_MAX),
      .Y_MIN         (Y_MIN),
      .Y_MAX         (Y_MAX)
    ) u_slot (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .alloc     (alloc[i]),
      .direction (dir_t'(bus.direction)),
      .ball_x    (bus.BallX),
      .ball_y    (bus.BallY),
      .upgraded  (bus.upgraded),
      .kill      (bus.kill[i]),
      .active    (active[i]),
      .pos_x     (px[i]),
      .pos_y     (py[i])
    );
  end

  always_comb begin
    bus.BulletX = '0;
    bus.BulletY = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bus.BulletX[10*i +: 10] = px[i];
      bus.BulletY[10*i +: 10] = py[i];
    end
  end

  assign bus.BulletS      = coord_t'(BULLET_SIZE);
  assign bus.bullet_on    = active;
  assign bus.active_count = cnt;
  assign bus.fire_event   = fire_event;

endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed frames push expectations into a
// queue; a monitor pops and compares them after each frame.
module tb_bullet_pool;
  import bullet_pkg::*;

  localparam int N = 4;

  logic frame_clk = 1'b0;
  logic Reset;

  bullet_pool_if #(.NUM_BULLETS(N)) bus ();

  bullet_pool #(.NUM_BULLETS(N)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus.slave)
  );

  always #5 frame_clk = ~frame_clk;

  typedef enum int {K_ON, K_X, K_Y, K_FE, K_CNT} kind_t;
  typedef struct {
    int    tag;
    kind_t kind;
    int    idx;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  event chk_ev;

  always @(posedge frame_clk) cyc <= cyc + 1;

  function automatic int act(kind_t k, int i);
    case (k)
      K_ON:  return int'(bus.bullet_on);
      K_X:   return int'(bus.BulletX[10*i +: 10]);
      K_Y:   return int'(bus.BulletY[10*i +: 10]);
      K_FE:  return int'(bus.fire_event);
      default: return int'(bus.active_count);
    endcase
  endfunction

  initial forever begin
    @(negedge frame_clk or chk_ev);
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t e;
      int   a;
      e = q.pop_front();
      a = act(e.kind, e.idx);
      n_chk++;
      if (a == e.val)
        n_pass++;
      else
        $display("FAIL %s: got %0d, required %0d (frame %0d)",
                 e.name, a, e.val, cyc);
    end
  end

  task automatic push(int tag, kind_t k, int i, int v, string nm);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.idx  = i;
    e.val  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic expn(kind_t k, int i, int v, string nm);
    push(cyc + 1, k, i, v, nm);
  endtask

  task automatic expc(kind_t k, int i, int v, string nm);
    push(cyc, k, i, v, nm);
  endtask

  task automatic step();
    @(posedge frame_clk);
    @(negedge frame_clk);
    #1;
  endtask

  task automatic idle(int n);
    bus.keycode = 8'd0;
    for (int i = 0; i < n; i++) begin
      expn(K_FE, 0, 0, "idle_fe");
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    Reset         = 1'b1;
    bus.keycode   = 8'd0;
    bus.direction = 2'b01;
    bus.BallX     = 10'd320;
    bus.BallY     = 10'd240;
    bus.upgraded  = 1'b0;
    bus.kill      = '0;
    @(negedge frame_clk);
    #1;
    expc(K_ON, 0, 0, "rst_on");
    expc(K_X, 0, 0, "rst_x0");
    expc(K_Y, 3, 0, "rst_y3");
    expc(K_FE, 0, 0, "rst_fe");
    expc(K_CNT, 0, 0, "rst_cnt");
    ->chk_ev;
    #1;
    Reset = 1'b0;

    // first shot, then hold the key for 20 frames total
    bus.keycode = KEY_SPACE;
    expn(K_FE, 0, 1, "t1_fire");
    expn(K_ON, 0, 1, "t1_on");
    expn(K_X, 0, 320, "t1_x0");
    expn(K_Y, 0, 240, "t1_y0");
    expn(K_CNT, 0, 1, "t1_cnt");
    step();
    expn(K_FE, 0, 0, "t1_fe_f1");
    expn(K_X, 0, 332, "t1_x0_f1");
    expn(K_Y, 0, 240, "t1_y0_f1");
    step();
    expn(K_X, 0, 344, "t1_x0_f2");
    expn(K_ON, 0, 1, "t1_on_f2");
    step();
    for (int i = 3; i < 20; i++) begin
      expn(K_FE, 0, 0, "t2_hold_fe");
      expn(K_ON, 0, 1, "t2_hold_on");
      step();
    end
    idle(1);
    bus.keycode = KEY_SPACE;
    expn(K_FE, 0, 1, "t2_refire");
    expn(K_ON, 0, 3, "t2_on");
    expn(K_X, 1, 320, "t2_x1");
    expn(K_X, 0, 572, "t2_x0");
    expn(K_CNT, 0, 2, "t2_cnt");
    step();

    // cooldown: blocked at +3 and +8, fires at +10
    bus.keycode = 8'd0;
    bus.kill    = 4'b0011;
    expn(K_ON, 0, 0, "t3_kill_on");
    expn(K_CNT, 0, 0, "t3_kill_cnt");
    step();
    bus.kill = '0;
    idle(1);
    bus.keycode = KEY_SPACE;
    expn(K_FE, 0, 0, "t3_cd_f3");
    expn(K_ON, 0, 0, "t3_cd_f3_on");
    step();
    idle(4);
    bus.keycode = KEY_SPACE;
    expn(K_FE, 0, 0, "t3_cd_f8");
    step();
    bus.BallX     = 10'd630;
    bus.direction = 2'b00;
    idle(1);
    bus.keycode = KEY_SPACE;
    expn(K_FE, 0, 1, "t3_fire");
    expn(K_ON, 0, 1, "t3_on");
    expn(K_X, 0, 630, "t3_x0");
    step();

    // fill the pool moving left from X=630
    idle(8);
    bus.keycode = KEY_SPACE;
    expn(K_FE, 0, 1, "t4_fire1");
    expn(K_ON, 0, 3, "t4_on1");
    expn(K_X, 0, 522, "t4_x0");
    step();
    idle(8);
    bus.keycode = KEY_SPACE;
    expn(K_FE, 0, 1, "t4_fire2");
    expn(K_ON, 0, 7, "t4_on2");
    step();
    idle(8);
    bus.keycode = KEY_SPACE;
    expn(K_FE, 0, 1, "t4_fire3");
    expn(K_ON, 0, 15, "t4_on3");
    expn(K_CNT, 0, 4, "t4_cnt_full");
    expn(K_X, 0, 306, "t4_x0_b");
    step();
    idle(8);
    bus.keycode = KEY_SPACE;
    expn(K_FE, 0, 0, "t4_full_fe");
    expn(K_CNT, 0, 4, "t4_full_cnt");
    step();
    bus.keycode = 8'd0;
    bus.kill    = 4'b0100;
    expn(K_ON, 0, 11, "t4_kill2_on");
    expn(K_CNT, 0, 3, "t4_kill2_cnt");
    step();
    bus.kill    = '0;
    bus.keycode = KEY_SPACE;
    expn(K_FE, 0, 1, "t4_realloc_fe");
    expn(K_ON, 0, 15, "t4_realloc_on");
    expn(K_X, 2, 630, "t4_x2");
    expn(K_X, 3, 498, "t4_x3");
    step();

    // left edge, normal then upgraded speed
    bus.keycode = 8'd0;
    bus.kill    = 4'b1111;
    bus.BallX   = 10'd14;
    expn(K_CNT, 0, 0, "t5_clear");
    step();
    bus.kill = '0;
    idle(7);
    bus.keycode = KEY_SPACE;
    expn(K_FE, 0, 1, "t5_fire");
    expn(K_X, 0, 14, "t5_x14");
    step();
    bus.keycode = 8'd0;
    expn(K_X, 0, 2, "t5_x2");
    expn(K_ON, 0, 1, "t5_on_x2");
    step();
    expn(K_ON, 0, 0, "t5_edge_off");
    step();
    bus.BallX    = 10'd20;
    bus.upgraded = 1'b1;
    idle(6);
    bus.keycode = KEY_SPACE;
    expn(K_FE, 0, 1, "t5u_fire");
    expn(K_X, 0, 20, "t5u_x20");
    step();
    bus.keycode = 8'd0;
    expn(K_X, 0, 2, "t5u_x2");
    expn(K_ON, 0, 1, "t5u_on_x2");
    step();
    expn(K_ON, 0, 0, "t5u_edge_off");
    step();
    expn(K_CNT, 0, 0, "t5u_no_wrap");
    step();

    // three bullets in flight, then async reset
    bus.BallX     = 10'd100;
    bus.upgraded  = 1'b0;
    bus.direction = 2'b01;
    idle(5);
    for (int s = 0; s < 3; s++) begin
      if (s > 0) idle(8);
      bus.keycode = KEY_SPACE;
      expn(K_FE, 0, 1, "t6_fire");
      step();
    end
    bus.keycode = 8'd0;
    expn(K_CNT, 0, 3, "t6_cnt3");
    expn(K_X, 0, 328, "t6_x0");
    step();
    Reset = 1'b1;
    #1;
    expc(K_ON, 0, 0, "t6_rst_on");
    expc(K_CNT, 0, 0, "t6_rst_cnt");
    expc(K_X, 0, 0, "t6_rst_x0");
    expc(K_X, 2, 0, "t6_rst_x2");
    expc(K_Y, 1, 0, "t6_rst_y1");
    ->chk_ev;
    #1;
    Reset = 1'b0;
    expn(K_ON, 0, 0, "t6_post_on");
    step();
    step();

    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d pending, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
- Parametrised projectile pool for one player: up to NUM_BULLETS bullets in flight at once.
- Each slot has its own latched direction, position and kill input.
- Adds a fire-rate cooldown, one-shot-per-press firing and lowest-free-slot allocation.
- Sits between the keyboard keycode and player-position logic and the collision and VGA colour-mapper logic. It is advanced once per frame_clk.

Parameters:
NUM_BULLETS, 4, number of bullet slots (1..8)
FIRE_KEY, 8'd44, keycode that fires
STEP, 12, per-frame displacement in pixels, normal mode
UPGRADE_BONUS, 6, extra displacement per frame while upgraded=1
COOLDOWN_FRAMES, 8, minimum number of frames between two shots
BULLET_SIZE, 2, bullet half-size in pixels
X_MIN, 1, left screen limit
X_MAX, 639, right screen limit
Y_MIN, 1, top screen limit
Y_MAX, 479, bottom screen limit

Ports:
frame_clk  in  1  frame clock; all state advances on its rising edge
Reset  in  1  reset
direction  in  2  player facing: 00 left, 01 right, 10 down, 11 up
keycode  in  8  current keyboard keycode
BallX  in  10  player centre X
BallY  in  10  player centre Y
upgraded  in  1  speed upgrade active
kill  in  NUM_BULLETS  per-slot hit (barrier, player, bullet or armor), level-sampled
BulletX  out  10*NUM_BULLETS  slot i X position at bits [10i+9:10i]
BulletY  out  10*NUM_BULLETS  slot i Y position at bits [10i+9:10i]
BulletS  out  10  constant BULLET_SIZE
bullet_on  out  NUM_BULLETS  slot active flags
active_count  out  $clog2(NUM_BULLETS+1)  population count of bullet_on (combinational)
fire_event  out  1  one-frame pulse in the frame a shot is launched

Behaviour:
- Reset is asynchronous, active-high; clock is frame_clk.
- Reset values:
  - bullet_on = 0, all BulletX/BulletY = 0, fire_event = 0.
  - Cooldown counter = 0; released flag = 1; latched directions = 00.
- Press tracking (one shot per press):
  - keycode == FIRE_KEY in a frame: released <= 0.
  - Any other keycode: released <= 1.
- Fire condition, all required: keycode == FIRE_KEY, released == 1, cooldown == 0, and at least one slot with bullet_on == 0 at the start of the frame.
- On fire:
  - The lowest-index free slot s is allocated: bullet_on[s] <= 1, dir[s] <= direction.
  - Slot s position is set to BallX/BallY.
  - cooldown <= COOLDOWN_FRAMES; fire_event <= 1 for that frame only.
- Fire with no free slot or cooldown != 0:
  - No shot, fire_event stays 0.
  - released still drops, so the player must re-press to fire.
- Cooldown: decrements by 1 each frame while nonzero and saturates at 0. With COOLDOWN_FRAMES = 0 there is no cooldown.
- Active slot motion, each frame, evaluated in this priority:
  1. Edge: deactivate if pos+BULLET_SIZE >= MAX, or pos <= MIN+BULLET_SIZE, on either axis.
  2. kill[i] = 1: deactivate.
  3. Otherwise move by d = STEP + (upgraded ? UPGRADE_BONUS : 0) in the latched direction; the other axis holds.
- Width rules:
  - Arithmetic is 10-bit unsigned modular.
  - A leftward or upward underflow wraps to ≥ 1000, which is ≥ MAX, so the edge check kills the slot next frame.
  - The bullet is visible for at most one frame at a wrapped position; the colour mapper must gate on bullet_on.
- Inactive slots track BallX/BallY every frame, so a newly fired bullet starts at the player.
- Deactivation is registered: a slot killed in frame n becomes free for allocation in frame n+1, not in frame n.
- Simultaneous events:
  - Different slots are independent.
  - kill on an inactive slot is ignored.
  - kill on the slot being allocated in the same frame is ignored; allocation wins.
- Latency: a fired bullet first appears at BallX/BallY in frame n+1 and moves from frame n+2.
- Reset mid-flight: all slots clear immediately, asynchronously.

Decomposition:
- Package bullet_pkg:
  - dir_t enum: LEFT = 2'b00, RIGHT = 2'b01, DOWN = 2'b10, UP = 2'b11.
  - Screen limit constants.
  - KEY_SPACE = 8'd44.
- Sub-module bullet_slot, instantiated NUM_BULLETS times:
  - Owns position, direction, active flag, edge check and kill handling.
  - Has load/alloc inputs.
- The top level holds press tracking, cooldown, a priority-encoder allocator, popcount and output packing.

Test Plan:
1. Reset, BallX=320, BallY=240, direction=01, keycode=44 for one frame, upgraded=0 → fire_event=1 that frame; slot0 on at X=320, then 332, 344 in the following frames; slots 1..3 stay off.
2. Hold keycode=44 for 20 frames → exactly one shot. Release and re-press with cooldown=0 → slot1 allocated; active_count=2.
3. COOLDOWN_FRAMES=8: press, release, press on frame 3 → no shot. Press on frame ≥9 after the first shot → shot.
4. Fill all 4 slots, then press again → no fire_event, active_count=4. Assert kill[2] → the next press allocates slot2, not slot3 or another slot.
5. direction=00 at BallX=14 → bullet at 14, then 2. Next frame the edge check clears it. Same test with upgraded=1 from X=20 (20→2 in one step of 18, then cleared); no slot remains on at a wrapped X.
6. Assert Reset while 3 bullets are mid-flight → bullet_on=0 and BulletX/BulletY=0 immediately, with no frame_clk edge needed.
